// File: rtl/egress_in_if.sv
// Stream and RAM-write bundle for the egress_in block.
// master: the side that drives the word stream and rd_done (core / transmitter).
// slave:  the egress_in block itself.
interface egress_in_if;
  logic [31:0] DATA_in;
  logic        DATA_en;
  logic        MODE_SET;
  logic        rd_done;
  logic        in_ready;
  logic        wrreq;
  logic [9:0]  wraddr;
  logic [31:0] DATA_wr;
  logic        pkt_ready;
  logic        pkt_half;
  logic [1:0]  full;
  logic        overflow;

  modport master (
    output DATA_in, DATA_en, MODE_SET, rd_done,
    input  in_ready, wrreq, wraddr, DATA_wr, pkt_ready, pkt_half, full, overflow
  );

  modport slave (
    input  DATA_in, DATA_en, MODE_SET, rd_done,
    output in_ready, wrreq, wraddr, DATA_wr, pkt_ready, pkt_half, full, overflow
  );
endinterface

// File: rtl/egress_in.sv
// Egress write side: packs a 32-bit word stream into a ping-pong RAM
// (two 512-word halves, wraddr[9] = half). When a half holds a whole
// packet it is flagged full and announced with a pkt_ready pulse; the
// reader frees halves in fill order with rd_done.
module egress_in #(
  parameter int CMD_WORDS = 32,   // packet length with MODE_SET=1
  parameter int DAT_WORDS = 256   // packet length with MODE_SET=0
) (
  input  logic        CLK,
  input  logic        nRST,
  egress_in_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1
  } state_e;

  localparam logic [8:0] CMD_LAST = 9'(CMD_WORDS - 1);
  localparam logic [8:0] DAT_LAST = 9'(DAT_WORDS - 1);

  state_e      state_q,    state_d;
  logic [8:0]  cnt_q,      cnt_d;
  logic        mode_q,     mode_d;      // 1 = command-length packet
  logic        wr_half_q,  wr_half_d;   // half currently being filled
  logic        rd_half_q,  rd_half_d;   // oldest full half (next to free)
  logic [1:0]  full_q,     full_d;
  logic        wrreq_q,    wrreq_d;
  logic [9:0]  wraddr_q,   wraddr_d;
  logic [31:0] data_wr_q,  data_wr_d;
  logic        pkt_ready_q, pkt_ready_d;
  logic        pkt_half_q, pkt_half_d;
  logic        overflow_q, overflow_d;

  logic        in_ready;
  logic        accept;
  logic        last_word;
  logic        free_half;
  logic [8:0]  last_idx;

  // Acceptance is purely a function of registered state, so upstream sees it
  // in the same cycle it presents a word.
  assign in_ready  = (state_q == ST_RUN) & ~full_q[wr_half_q];
  assign accept    = bus.DATA_en & in_ready;
  assign last_idx  = mode_q ? CMD_LAST : DAT_LAST;
  assign last_word = (cnt_q == last_idx);
  // A rd_done against an empty half is stray and must not move the read pointer.
  assign free_half = bus.rd_done & full_q[rd_half_q];

  // Next-state and registered-output computation.
  // NOTE: every signal assigned here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_half_d   = wr_half_q;
    rd_half_d   = rd_half_q;
    full_d      = full_q;
    wrreq_d     = 1'b0;
    wraddr_d    = wraddr_q;
    data_wr_d   = data_wr_q;
    pkt_ready_d = 1'b0;
    pkt_half_d  = pkt_half_q;
    overflow_d  = overflow_q | (bus.DATA_en & ~in_ready);
    // Length follows MODE_SET until the first word of a packet is taken,
    // then stays frozen until the packet closes.
    mode_d      = (cnt_q == 9'd0) ? bus.MODE_SET : mode_q;

    case (state_q)
      ST_INIT: begin
        cnt_d     = 9'd0;
        wr_half_d = 1'b0;
        rd_half_d = 1'b0;
        full_d    = 2'b00;
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        if (accept) begin
          wrreq_d   = 1'b1;
          wraddr_d  = {wr_half_q, cnt_q};
          data_wr_d = bus.DATA_in;
          if (last_word) begin
            // Close the packet: the half becomes visible to the reader and
            // writing moves on to the other half.
            cnt_d             = 9'd0;
            full_d[wr_half_q] = 1'b1;
            wr_half_d         = ~wr_half_q;
            pkt_ready_d       = 1'b1;
            pkt_half_d        = wr_half_q;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
        // The half being freed is never the one just set (a half is only set
        // while free), so both updates can land in the same cycle.
        if (free_half) begin
          full_d[rd_half_q] = 1'b0;
          rd_half_d         = ~rd_half_q;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_INIT;
      cnt_q       <= 9'd0;
      mode_q      <= 1'b0;
      wr_half_q   <= 1'b0;
      rd_half_q   <= 1'b0;
      full_q      <= 2'b00;
      wrreq_q     <= 1'b0;
      wraddr_q    <= 10'd0;
      data_wr_q   <= 32'd0;
      pkt_ready_q <= 1'b0;
      pkt_half_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      wr_half_q   <= wr_half_d;
      rd_half_q   <= rd_half_d;
      full_q      <= full_d;
      wrreq_q     <= wrreq_d;
      wraddr_q    <= wraddr_d;
      data_wr_q   <= data_wr_d;
      pkt_ready_q <= pkt_ready_d;
      pkt_half_q  <= pkt_half_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.wrreq     = wrreq_q;
  assign bus.wraddr    = wraddr_q;
  assign bus.DATA_wr   = data_wr_q;
  assign bus.pkt_ready = pkt_ready_q;
  assign bus.pkt_half  = pkt_half_q;
  assign bus.full      = full_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_egress_in.sv
// Directed bench for egress_in: packet fill in both modes, both-full
// back-pressure and overflow, rd_done ordering, simultaneous set/clear,
// mid-packet mode change and reset mid-packet.
module tb_egress_in;

  logic clk;
  logic nrst;
  int   total;
  int   bad;

  egress_in_if bus ();

  egress_in #(
    .CMD_WORDS (32),
    .DAT_WORDS (256)
  ) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got=running want=finished");
    $fatal(1, "watchdog");
  end

  // Assert reset, check every output is zero, release, and check that
  // in_ready is low for the INIT cycle and high from the next cycle on.
  task automatic reset_and_release(input string tag);
    nrst        = 1'b0;
    bus.DATA_en = 1'b0;
    bus.rd_done = 1'b0;
    #1;
    total++;
    if ({bus.in_ready, bus.wrreq, bus.wraddr, bus.DATA_wr, bus.pkt_ready,
         bus.pkt_half, bus.full, bus.overflow} !== 49'd0) begin
      bad++;
      $display("FAIL %s_outputs_in_reset: rdy=%b wrreq=%b addr=%h data=%h pkt=%b half=%b full=%b ovf=%b want all 0",
               tag, bus.in_ready, bus.wrreq, bus.wraddr, bus.DATA_wr, bus.pkt_ready,
               bus.pkt_half, bus.full, bus.overflow);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_in_ready_init: got=%b want=0", tag, bus.in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_in_ready_run: got=%b want=1", tag, bus.in_ready);
    end
  endtask

  // Stream n consecutive words into one half and check every RAM write.
  // plen is the packet length in force, so pkt_ready is expected only on
  // index plen-1. switch_after flips MODE_SET after that index is taken.
  task automatic send_packet(input int n, input int plen, input logic half,
                             input logic [31:0] base, input int switch_after,
                             input bit rd_last);
    logic [9:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_pkt;
    for (int i = 0; i < n; i++) begin
      bus.DATA_en = 1'b1;
      bus.DATA_in = base + 32'(i);
      bus.rd_done = rd_last && (i == n - 1);
      @(posedge clk); #1;
      exp_addr = {half, 9'(i)};
      exp_data = base + 32'(i);
      exp_pkt  = (i == plen - 1);
      total++;
      if (bus.wrreq !== 1'b1) begin
        bad++;
        $display("FAIL pkt_wrreq idx=%0d: got=%b want=1", i, bus.wrreq);
      end
      total++;
      if (bus.wraddr !== exp_addr) begin
        bad++;
        $display("FAIL pkt_wraddr idx=%0d: got=%h want=%h", i, bus.wraddr, exp_addr);
      end
      total++;
      if (bus.DATA_wr !== exp_data) begin
        bad++;
        $display("FAIL pkt_data idx=%0d: got=%h want=%h", i, bus.DATA_wr, exp_data);
      end
      total++;
      if (bus.pkt_ready !== exp_pkt) begin
        bad++;
        $display("FAIL pkt_ready idx=%0d: got=%b want=%b", i, bus.pkt_ready, exp_pkt);
      end
      if (exp_pkt) begin
        total++;
        if (bus.pkt_half !== half) begin
          bad++;
          $display("FAIL pkt_half idx=%0d: got=%b want=%b", i, bus.pkt_half, half);
        end
      end
      if (i == switch_after) bus.MODE_SET = ~bus.MODE_SET;
    end
    bus.DATA_en = 1'b0;
    bus.rd_done = 1'b0;
  endtask

  task automatic pulse_rd();
    bus.rd_done = 1'b1;
    @(posedge clk); #1;
    bus.rd_done = 1'b0;
  endtask

  task automatic expect_full(input string tag, input logic [1:0] exp);
    total++;
    if (bus.full !== exp) begin
      bad++;
      $display("FAIL %s_full: got=%b want=%b", tag, bus.full, exp);
    end
  endtask

  task automatic test_reset();
    reset_and_release("reset");
    expect_full("reset", 2'b00);
  endtask

  task automatic test_cmd_packet();
    bus.MODE_SET = 1'b1;
    send_packet(32, 32, 1'b0, 32'h0000_0000, -1, 1'b0);
    expect_full("cmd", 2'b01);
    @(posedge clk); #1;
    total++;
    if (bus.wrreq !== 1'b0 || bus.pkt_ready !== 1'b0) begin
      bad++;
      $display("FAIL cmd_idle_pulses: wrreq=%b pkt=%b want 0/0", bus.wrreq, bus.pkt_ready);
    end
    total++;
    if (bus.wraddr !== 10'h01F) begin
      bad++;
      $display("FAIL cmd_wraddr_hold: got=%h want=01f", bus.wraddr);
    end
  endtask

  task automatic test_data_fill();
    reset_and_release("fill");
    bus.MODE_SET = 1'b0;
    send_packet(256, 256, 1'b0, 32'hA000_0000, -1, 1'b0);
    send_packet(256, 256, 1'b1, 32'hB000_0000, -1, 1'b0);
    expect_full("fill", 2'b11);
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL fill_in_ready: got=%b want=0", bus.in_ready);
    end
    bus.DATA_en = 1'b1;
    bus.DATA_in = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.DATA_en = 1'b0;
    total++;
    if (bus.wrreq !== 1'b0) begin
      bad++;
      $display("FAIL ovf_wrreq: got=%b want=0", bus.wrreq);
    end
    total++;
    if (bus.overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_flag: got=%b want=1", bus.overflow);
    end
    total++;
    if (bus.wraddr !== 10'h2FF || bus.DATA_wr !== 32'hB000_00FF) begin
      bad++;
      $display("FAIL ovf_hold: addr=%h data=%h want 2ff/b00000ff", bus.wraddr, bus.DATA_wr);
    end
  endtask

  task automatic test_rd_done();
    pulse_rd();
    expect_full("rd1", 2'b10);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rd1_in_ready: got=%b want=1", bus.in_ready);
    end
    total++;
    if (bus.overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: got=%b want=1", bus.overflow);
    end
    pulse_rd();
    expect_full("rd2", 2'b00);
    // Stray rd_done with nothing full: must not advance the read pointer.
    pulse_rd();
    expect_full("rd_stray", 2'b00);
    bus.MODE_SET = 1'b1;
    send_packet(32, 32, 1'b0, 32'hC000_0000, -1, 1'b0);
    expect_full("rd_refill", 2'b01);
  endtask

  task automatic test_simultaneous();
    // Half 0 full, last word of half 1 lands with rd_done: 01 -> 10.
    send_packet(32, 32, 1'b1, 32'hD000_0000, -1, 1'b1);
    expect_full("simul", 2'b10);
  endtask

  task automatic test_mode_change();
    bus.MODE_SET = 1'b1;
    send_packet(32, 32, 1'b0, 32'hE000_0000, 5, 1'b0);
    expect_full("mode_cmd", 2'b11);
    pulse_rd();
    expect_full("mode_rd", 2'b01);
    send_packet(256, 256, 1'b1, 32'hF000_0000, -1, 1'b0);
    expect_full("mode_dat", 2'b11);
  endtask

  task automatic test_reset_mid();
    pulse_rd();
    pulse_rd();
    expect_full("mid_pre", 2'b00);
    bus.MODE_SET = 1'b0;
    send_packet(100, 256, 1'b0, 32'h1234_0000, -1, 1'b0);
    bus.DATA_en = 1'b1;
    bus.DATA_in = 32'h1234_0064;
    #2;
    reset_and_release("mid");
    total++;
    if (bus.wraddr !== 10'h000 || bus.pkt_ready !== 1'b0 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL mid_after_release: addr=%h pkt=%b ovf=%b want 000/0/0",
               bus.wraddr, bus.pkt_ready, bus.overflow);
    end
    send_packet(256, 256, 1'b0, 32'h5555_0000, -1, 1'b0);
    expect_full("mid_post", 2'b01);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    nrst         = 1'b0;
    bus.DATA_in  = 32'd0;
    bus.DATA_en  = 1'b0;
    bus.MODE_SET = 1'b0;
    bus.rd_done  = 1'b0;

    test_reset();
    test_cmd_packet();
    test_data_fill();
    test_rd_done();
    test_simultaneous();
    test_mode_change();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
